// File: rtl/rx_tx_pkg.sv
// Shared egress datapath types: byte width, link-table entry layout and the
// frame reader state encoding.
package rx_tx_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned PTR_W      = 6;

    typedef struct packed {
        logic             last;
        logic [PTR_W-1:0] next;
    } link_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        HOLD,
        FREE
    } rd_state_e;

endpackage

// File: rtl/egress_frame_reader.sv
// Egress frame reader: walks a linked chain of buffer blocks, presents each
// block to the TX MAC and returns consumed blocks to the free list.
module egress_frame_reader
    import rx_tx_pkg::*;
#(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned BLOCK_BYTES = 64,
    parameter int unsigned MAX_BLOCKS  = 24
) (
    input  logic                              switch_clk,
    input  logic                              switch_rst_n,
    input  logic                              mem_start_i,
    input  logic [ADDR_W-1:0]                 mem_start_addr_i,
    input  logic                              mem_re_i,
    output logic [BLOCK_BYTES*DATA_WIDTH-1:0] frame_data_o,
    output logic                              frame_valid_o,
    output logic                              frame_end_o,
    output logic                              buf_rd_en_o,
    output logic [ADDR_W-1:0]                 buf_rd_addr_o,
    input  logic [BLOCK_BYTES*DATA_WIDTH-1:0] buf_rd_data_i,
    input  logic [ADDR_W:0]                   link_rd_data_i,
    output logic                              free_valid_o,
    output logic [ADDR_W-1:0]                 free_ptr_o,
    input  logic                              free_ready_i,
    output logic                              proto_err_o
);

    localparam int unsigned FRAME_W = BLOCK_BYTES * DATA_WIDTH;
    localparam int unsigned CNT_W   = $clog2(MAX_BLOCKS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BLOCKS - 1);

    rd_state_e          state_q;
    logic [ADDR_W-1:0]  cur_ptr_q;
    logic [ADDR_W-1:0]  next_ptr_q;
    logic               end_q;
    logic [CNT_W-1:0]   blk_cnt_q;
    logic [FRAME_W-1:0] frame_data_q;
    logic               frame_valid_q;
    logic               frame_end_q;
    logic               buf_rd_en_q;
    logic [ADDR_W-1:0]  buf_rd_addr_q;
    logic               free_valid_q;
    logic [ADDR_W-1:0]  free_ptr_q;
    logic               proto_err_q;

    logic link_last;
    logic at_limit;
    logic block_end;

    assign link_last = link_rd_data_i[ADDR_W];
    assign at_limit  = (blk_cnt_q == LAST_CNT);
    assign block_end = link_last | at_limit;

    // Chain walker FSM; every output is a register.
    always_ff @(posedge switch_clk or negedge switch_rst_n) begin
        if (!switch_rst_n) begin
            state_q       <= IDLE;
            cur_ptr_q     <= '0;
            next_ptr_q    <= '0;
            end_q         <= 1'b0;
            blk_cnt_q     <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            frame_end_q   <= 1'b0;
            buf_rd_en_q   <= 1'b0;
            buf_rd_addr_q <= '0;
            free_valid_q  <= 1'b0;
            free_ptr_q    <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            buf_rd_en_q <= 1'b0;
            proto_err_q <= (mem_start_i && (state_q != IDLE)) ||
                           (mem_re_i && !frame_valid_q);

            case (state_q)
                IDLE: begin
                    if (mem_start_i) begin
                        cur_ptr_q <= mem_start_addr_i;
                        blk_cnt_q <= '0;
                        state_q   <= FETCH;
                    end
                end

                FETCH: begin
                    buf_rd_en_q   <= 1'b1;
                    buf_rd_addr_q <= cur_ptr_q;
                    state_q       <= CAPTURE;
                end

                // The strobe is registered, so RAM data lands one cycle after
                // CAPTURE is entered; the still-high strobe marks that wait cycle.
                CAPTURE: begin
                    if (!buf_rd_en_q) begin
                        frame_data_q  <= buf_rd_data_i;
                        next_ptr_q    <= link_rd_data_i[ADDR_W-1:0];
                        end_q         <= block_end;
                        frame_valid_q <= 1'b1;
                        frame_end_q   <= block_end;
                        blk_cnt_q     <= blk_cnt_q + CNT_W'(1);
                        if (at_limit && !link_last) begin
                            proto_err_q <= 1'b1;
                        end
                        state_q <= HOLD;
                    end
                end

                HOLD: begin
                    if (mem_re_i) begin
                        frame_valid_q <= 1'b0;
                        frame_end_q   <= 1'b0;
                        free_valid_q  <= 1'b1;
                        free_ptr_q    <= cur_ptr_q;
                        state_q       <= FREE;
                    end
                end

                FREE: begin
                    if (free_ready_i) begin
                        free_valid_q <= 1'b0;
                        if (end_q) begin
                            state_q <= IDLE;
                        end else begin
                            cur_ptr_q <= next_ptr_q;
                            state_q   <= FETCH;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign frame_data_o  = frame_data_q;
    assign frame_valid_o = frame_valid_q;
    assign frame_end_o   = frame_end_q;
    assign buf_rd_en_o   = buf_rd_en_q;
    assign buf_rd_addr_o = buf_rd_addr_q;
    assign free_valid_o  = free_valid_q;
    assign free_ptr_o    = free_ptr_q;
    assign proto_err_o   = proto_err_q;

endmodule
